// File: rtl/instr_reg_ctrl_pkg.sv
// Purpose: shared types and constants for the instruction register front-end controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: operand/opcode/address types of the instruction register, the controller
// state enum, the register depth and the per-producer request record.
package instr_reg_ctrl_pkg;

    // Instruction register field types.
    typedef logic signed [31:0] operand_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic [4:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // Controller state: INIT zero-fills every entry, RUN is normal queue operation.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam int IREG_DEPTH = 32;

    // One extra bit so that a completely full register (count == depth) is representable.
    localparam int COUNT_W = $clog2(IREG_DEPTH) + 1;
    typedef logic [COUNT_W-1:0] count_t;

    // Write payload offered by a producer.
    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
    } req_t;

    // Payload driven onto the register write port whenever nothing is being written.
    localparam req_t REQ_IDLE = '{opcode: ZERO, operand_a: '0, operand_b: '0};

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Purpose: bundle of producer, consumer and register-side signals of the controller.
// Latency: n/a (wires only).
// Backpressure: reqN_ready / rd_valid carry the handshakes; nothing is buffered here.
//
// Ports (slave = controller side):
//   req0_*/req1_*  producer valid/ready handshakes and write payloads
//   rd_valid/rd_ready  consumer pop handshake for the head entry
//   flush          discard all queued entries
//   busy/full/empty/count  queue status
//   load_en/opcode/operand_a/operand_b/write_pointer/read_pointer  register port
interface instr_reg_ctrl_if;
    import instr_reg_ctrl_pkg::*;

    logic     req0_valid;
    logic     req0_ready;
    opcode_t  req0_opcode;
    operand_t req0_operand_a;
    operand_t req0_operand_b;

    logic     req1_valid;
    logic     req1_ready;
    opcode_t  req1_opcode;
    operand_t req1_operand_a;
    operand_t req1_operand_b;

    logic     rd_valid;
    logic     rd_ready;
    logic     flush;

    logic     busy;
    logic     full;
    logic     empty;
    count_t   count;

    logic     load_en;
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
    address_t write_pointer;
    address_t read_pointer;

    // Controller side.
    modport slave (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  rd_ready, flush,
        output req0_ready, req1_ready, rd_valid,
        output busy, full, empty, count,
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer
    );

    // Producer / consumer / register side.
    modport master (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output rd_ready, flush,
        input  req0_ready, req1_ready, rd_valid,
        input  busy, full, empty, count,
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer
    );

endinterface

// File: rtl/instr_reg_ctrl_rr_arb2.sv
// Purpose: two-way round-robin arbiter with a registered last-grant pointer.
// Latency: grant is combinational from valid; last_grant updates on the accepting edge.
// Backpressure: accept_en low suppresses every grant and freezes the priority pointer.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (last_grant -> 1)
//   valid[1:0]   request lines, bit N = producer N
//   accept_en    downstream can take a write this cycle
//   grant[1:0]   one-hot grant, only while accept_en is high
//   grant_vld    a write is accepted this cycle
//   grant_idx    index of the winning producer (ungated, used as the data mux select)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept_en,
    output logic [1:0] grant,
    output logic       grant_vld,
    output logic       grant_idx
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_idx = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            // Contention: the producer that did not win last time goes first.
            2'b11:   grant_idx = ~last_grant_q;
            default: grant_idx = 1'b0;
        endcase

        grant_vld = accept_en && (|valid);

        grant = 2'b00;
        if (grant_vld) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end

        last_grant_d = grant_vld ? grant_idx : last_grant_q;
    end

    // Reset to 1 so producer 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Purpose: write/read controller that runs the instruction register as a circular queue.
// Latency: write strobes on the accepting edge; entry visible on rd_valid the next cycle.
// Backpressure: producers stall (ready low) when full, busy or flushing; pops need rd_ready.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   bus (slave)     producer handshakes req0_*/req1_*, consumer rd_valid/rd_ready, flush,
//                   status busy/full/empty/count and the register port load_en, opcode,
//                   operand_a, operand_b, write_pointer, read_pointer
module instr_reg_ctrl
    import instr_reg_ctrl_pkg::*;
#(
    parameter int DEPTH         = IREG_DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    instr_reg_ctrl_if.slave bus
);

    // Pointer wrap relies on the address width exactly spanning the register.
    if (DEPTH != (1 << $bits(address_t))) begin : g_depth_check
        $error("instr_reg_ctrl: DEPTH must equal 2**$bits(address_t)");
    end

    localparam ctrl_state_t RESET_STATE = INIT_ON_RESET ? INIT : RUN;

    ctrl_state_t state_q,    state_d;
    address_t    head_q,     head_d;
    address_t    tail_q,     tail_d;
    address_t    init_ptr_q, init_ptr_d;
    count_t      count_q,    count_d;

    logic        run;
    logic        full_int;
    logic        empty_int;
    logic        accept_en;
    logic        push;
    logic        pop;
    logic        sel_idx;
    logic [1:0]  grant;
    req_t        req0;
    req_t        req1;
    req_t        wr_req;

    // Write acceptance never looks at rd_ready: a full queue refuses the write even when
    // the head is popped in the same cycle, so ready has no combinational consumer path.
    always_comb begin
        run       = (state_q == RUN);
        full_int  = (count_q == count_t'(DEPTH));
        empty_int = (count_q == '0);
        accept_en = run && !full_int && !bus.flush;
        pop       = run && !empty_int && bus.rd_ready && !bus.flush;
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .accept_en (accept_en),
        .grant     (grant),
        .grant_vld (push),
        .grant_idx (sel_idx)
    );

    // Next-state logic for the sweep pointer, queue pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        init_ptr_d = init_ptr_q;
        count_d    = count_q;

        case (state_q)
            INIT: begin
                // Flush is deliberately ignored while sweeping.
                init_ptr_d = init_ptr_q + address_t'(1);
                if (init_ptr_q == address_t'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    head_d     = '0;
                    tail_d     = '0;
                    count_d    = '0;
                    init_ptr_d = '0;
                    state_d    = RESET_STATE;
                end else begin
                    if (push) begin
                        tail_d = tail_q + address_t'(1);
                    end
                    if (pop) begin
                        head_d = head_q + address_t'(1);
                    end
                    case ({push, pop})
                        2'b10:   count_d = count_q + count_t'(1);
                        2'b01:   count_d = count_q - count_t'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
        endcase
    end

    // Register port and status outputs.
    always_comb begin
        req0 = '{opcode: bus.req0_opcode, operand_a: bus.req0_operand_a,
                 operand_b: bus.req0_operand_b};
        req1 = '{opcode: bus.req1_opcode, operand_a: bus.req1_operand_a,
                 operand_b: bus.req1_operand_b};

        // The sweep writes REQ_IDLE too, so the payload only differs on accepted pushes.
        wr_req = REQ_IDLE;
        if (push) begin
            wr_req = sel_idx ? req1 : req0;
        end

        bus.load_en       = !run || push;
        bus.write_pointer = run ? tail_q : init_ptr_q;
        bus.opcode        = wr_req.opcode;
        bus.operand_a     = wr_req.operand_a;
        bus.operand_b     = wr_req.operand_b;
        bus.read_pointer  = head_q;

        bus.req0_ready    = grant[0];
        bus.req1_ready    = grant[1];
        bus.rd_valid      = run && !empty_int;

        bus.busy          = !run;
        bus.full          = full_int;
        bus.empty         = empty_int;
        bus.count         = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            head_q     <= '0;
            tail_q     <= '0;
            init_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            init_ptr_q <= init_ptr_d;
            count_q    <= count_d;
        end
    end

    // Structural invariants of the queue.
    a_one_ready : assert property (@(posedge clk) disable iff (reset)
        !(bus.req0_ready && bus.req1_ready));
    a_count_max : assert property (@(posedge clk) disable iff (reset)
        count_q <= count_t'(DEPTH));
    a_ptr_span : assert property (@(posedge clk) disable iff (reset)
        address_t'(count_q) == address_t'(tail_q - head_q));

endmodule
